mo_pixel_shifter: RTL
=====================

# mo_pixel_shifter

Motion-object pixel serializer that sits upstream of the motion object horizontal line buffer and produces the MOSR pixel stream that buffer writes. It accepts one 8-pixel, 4-bitplane graphics word plus palette code and flip flag per handshake. It double-buffers the word and shifts out one 7-bit pixel per MCKR, with optional horizontal mirroring. When it has nothing to send, it drives the transparent code so the line buffer suppresses writes.

## Interface
- COLOR_W, 3, width of palette/color code carried in MOSR[6:4]
- PIX_W, 4, bits per pixel (one per bitplane), carried in MOSR[3:0]
- MCKR  in  1  pixel clock; all state changes on its rising edge
- RESET_b  in  1  asynchronous, active-low reset
- PD  in  32  graphics word: plane3=PD[31:24], plane2=PD[23:16], plane1=PD[15:8], plane0=PD[7:0]
- PCOLOR  in  3  palette code for the word
- PFLIP  in  1  horizontal flip for the word
- LD_VALID  in  1  word/PCOLOR/PFLIP valid
- LD_READY  out  1  holding register can accept a word
- ABORT  in  1  synchronous flush of hold and shifter (line-buffer swap)
- MOSR  out  7  {color[2:0], pix[3:0]}; transparent = 7'h0F
- MOVLD  out  1  MOSR carries a real pixel this cycle
- LAST  out  1  current pixel is the final pixel of the stream (pixel 7, hold empty)

## Operation
- Storage: holding register (HOLD: PD, PCOLOR, PFLIP, HFULL flag) and shift register (SR: 4 planes × 8 bits, color, flip), plus 3-bit pixel counter PCNT.
- Accept: at a rising edge where LD_VALID & LD_READY, capture PD/PCOLOR/PFLIP into HOLD and set HFULL.
- LD_READY = RESET_b & ~HFULL & ~ABORT. This is combinational, with no dependency on LD_VALID.
- State machine, 2 states:
  - IDLE: MOSR = 7'h0F, MOVLD = 0. If HFULL, transfer HOLD→SR, clear HFULL, PCNT=0, go SHIFT.
  - SHIFT: output pixel PCNT and increment PCNT.
  - SHIFT at PCNT=7 with HFULL: transfer HOLD→SR, clear HFULL, PCNT=0, stay in SHIFT.
  - SHIFT at PCNT=7 with ~HFULL: go IDLE.
- Accept and transfer in the same edge are allowed: HFULL stays set (cleared by the transfer, set by the accept).
- Pixel select:
  - PFLIP=0: pixel k = {plane3[7-k], plane2[7-k], plane1[7-k], plane0[7-k]}.
  - PFLIP=1: pixel k uses bit k of each plane.
- MOSR in SHIFT = {SR color, pixel}. MOVLD = 1 in SHIFT, including pixels whose value is 4'hF.
- A pixel value of 4'hF is transparent data: it is emitted unchanged, and the line buffer suppresses the write.
- LAST = SHIFT & PCNT==7 & ~HFULL.
- ABORT has priority over everything. At the edge: HFULL=0, state=IDLE, PCNT=0, and no accept, even if LD_VALID is high.
- Reset values: state IDLE, HFULL=0, PCNT=0, SR=0, MOSR=7'h0F, MOVLD=0, LAST=0, LD_READY=0 while RESET_b low.
- Reset asserted mid-word: all outputs go to their reset values immediately (asynchronous), and the word is discarded.

## Timing
- Outputs MOSR/MOVLD/LAST are registered, decoded from SR/PCNT/state with no combinational path from inputs.
- Latency from accept at edge N while IDLE:
  - transfer at edge N+1; pixel 0 on MOSR after edge N+1;
  - pixel k after edge N+1+k; MOVLD falls after edge N+9 if nothing else is queued.
- Back-to-back: if the next word is in HOLD by the edge that ends pixel 7, its pixel 0 follows with zero gap.
- Throughput: 1 word per 8 MCKR sustained.
- LD_READY drops the cycle after accept. It rises the cycle after the transfer edge, or after the ABORT edge once ABORT is low.
- Release of RESET_b: first accept is possible at the first rising edge where RESET_b is high and LD_READY is high.

## Test plan
- Reset then idle. Hold RESET_b low 3 clocks, release, no LD_VALID. Required: MOSR=7'h0F, MOVLD=0, LAST=0 throughout; LD_READY=1 after release.
- Single word, no flip. PD=32'h0000_0080, PCOLOR=5, PFLIP=0, accept at edge N. Required: MOSR=7'h51 after edge N+1, then 7'h50 for 7 cycles; LAST with pixel 7; 7'h0F after edge N+9.
- Flip. Same word with PFLIP=1. Required: 7'h50 ×7, then 7'h51 as pixel 7.
- Back-to-back plus backpressure. Hold LD_VALID high with 3 words: 32'hFFFF_FFFF color 2, 32'h0 color 7, 32'hFF00_0000 color 1. Required:
  - 24 contiguous MOVLD cycles: 7'h2F ×8, 7'h70 ×8, 7'h18 ×8;
  - LD_READY low while HOLD is full; LAST only on the 24th pixel.
- ABORT. Assert ABORT for 1 cycle at pixel 3 of a word, with HOLD full and LD_VALID high. Required:
  - MOSR=7'h0F and MOVLD=0 after that edge; neither word is emitted; nothing accepted that edge;
  - the next accept streams normally.
- Async reset mid-stream. Drop RESET_b between edges during pixel 5. Required: MOSR=7'h0F and MOVLD=0 immediately, without waiting for a clock edge; no residual pixels after release.

Source files
------------

// File: rtl/mo_pixel_shifter_if.sv
// Load-side handshake for the motion-object pixel shifter: one graphics word,
// palette code and flip flag per LD_VALID/LD_READY transfer.
interface mo_pixel_shifter_if;
  localparam int unsigned PD_W    = 32;
  localparam int unsigned COLOR_W = 3;

  logic [PD_W-1:0]    PD;
  logic [COLOR_W-1:0] PCOLOR;
  logic               PFLIP;
  logic               LD_VALID;
  logic               LD_READY;

  modport master (output PD, output PCOLOR, output PFLIP, output LD_VALID, input  LD_READY);
  modport slave  (input  PD, input  PCOLOR, input  PFLIP, input  LD_VALID, output LD_READY);
endinterface

// File: rtl/mo_pixel_shifter.sv
// Motion-object pixel serializer: double-buffers 8-pixel, 4-plane words and
// emits one {color, pixel} per MCKR toward the line buffer, transparent when idle.
module mo_pixel_shifter (
  input  logic                   MCKR,
  input  logic                   RESET_b,
  mo_pixel_shifter_if.slave      ld,
  input  logic                   ABORT,
  output logic [6:0]             MOSR,
  output logic                   MOVLD,
  output logic                   LAST
);
  localparam int unsigned COLOR_W = 3;
  localparam int unsigned PIX_W   = 4;
  localparam int unsigned PIX_N   = 8;
  localparam int unsigned PD_W    = PIX_W * PIX_N;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned MOSR_W  = COLOR_W + PIX_W;
  localparam logic [MOSR_W-1:0] TRANSPARENT = MOSR_W'(7'h0F);
  localparam logic [CNT_W-1:0]  PCNT_LAST   = CNT_W'(PIX_N - 1);

  typedef struct packed {
    logic [PD_W-1:0]    pd;
    logic [COLOR_W-1:0] color;
    logic               flip;
  } word_t;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_q, state_d;
  word_t             hold_q, sr_q, sr_d;
  logic              hfull_q, hfull_d;
  logic [CNT_W-1:0]  pcnt_q, pcnt_d;
  logic              ld_ready, accept;
  logic [MOSR_W-1:0] mosr_d;
  logic              movld_d, last_d;

  // Unflipped words emit MSB first; flip reverses bit order across all planes.
  function automatic logic [PIX_W-1:0] pick(input word_t w, input logic [CNT_W-1:0] k);
    logic [CNT_W-1:0] idx;
    idx = w.flip ? k : ~k;
    return {w.pd[{2'd3, idx}], w.pd[{2'd2, idx}], w.pd[{2'd1, idx}], w.pd[{2'd0, idx}]};
  endfunction

  assign ld_ready    = RESET_b & ~hfull_q & ~ABORT;
  assign ld.LD_READY = ld_ready;
  assign accept      = ld.LD_VALID & ld_ready;

  // Next-state and output decode; outputs are registered from the next state.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    pcnt_d  = pcnt_q;
    hfull_d = hfull_q;
    mosr_d  = TRANSPARENT;
    movld_d = 1'b0;
    last_d  = 1'b0;

    if (ABORT) begin
      state_d = IDLE;
      pcnt_d  = '0;
      hfull_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hfull_q) begin
            sr_d    = hold_q;
            pcnt_d  = '0;
            hfull_d = 1'b0;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (pcnt_q == PCNT_LAST) begin
            pcnt_d = '0;
            if (hfull_q) begin
              sr_d    = hold_q;
              hfull_d = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            pcnt_d = pcnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
      if (accept) hfull_d = 1'b1;
    end

    if (state_d == SHIFT) begin
      mosr_d  = {sr_d.color, pick(sr_d, pcnt_d)};
      movld_d = 1'b1;
      last_d  = (pcnt_d == PCNT_LAST) & ~hfull_d;
    end
  end

  // State, storage and output registers.
  always_ff @(posedge MCKR or negedge RESET_b) begin
    if (!RESET_b) begin
      state_q <= IDLE;
      hold_q  <= '0;
      sr_q    <= '0;
      hfull_q <= 1'b0;
      pcnt_q  <= '0;
      MOSR    <= TRANSPARENT;
      MOVLD   <= 1'b0;
      LAST    <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      hfull_q <= hfull_d;
      pcnt_q  <= pcnt_d;
      MOSR    <= mosr_d;
      MOVLD   <= movld_d;
      LAST    <= last_d;
      if (accept) hold_q <= {ld.PD, ld.PCOLOR, ld.PFLIP};
    end
  end
endmodule
